// File: rtl/spi_cs_seq_if.sv
// MCU SPI bus, peripheral MISO/CS fan-out and status bundle for spi_cs_sequencer.
// master = MCU/environment side, slave = the sequencer.
interface spi_cs_seq_if #(
  parameter int N_PERIPH = 8
);
  logic                spi_sck;
  logic                spi_cs_n;
  logic                spi_mosi;
  logic                special;
  logic [N_PERIPH-1:0] periph_miso;
  logic                spi_miso;
  logic [N_PERIPH-1:0] cs_vec;
  logic [N_PERIPH-1:0] reg_mux;
  logic                frame_err;
  logic                busy;

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, special, periph_miso,
    input  spi_miso, cs_vec, reg_mux, frame_err, busy
  );

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, special, periph_miso,
    output spi_miso, cs_vec, reg_mux, frame_err, busy
  );
endinterface

// File: rtl/spi_cs_sequencer.sv
// Shared MCU SPI bus owner: routes frames to mux-selected peripheral chip-selects or
// writes the mux register. Define SPI_CS_SEQ_READBACK_EN to shift the old register out on MISO.
module spi_cs_sequencer #(
  parameter int                  N_PERIPH  = 8,
  parameter logic [N_PERIPH-1:0] RESET_MUX = '0
) (
  input logic          clk,
  input logic          rst_n,
  spi_cs_seq_if.slave  bus
);
  localparam int                CNT_W    = $clog2(N_PERIPH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_PERIPH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_PERIPH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PERIPH = 2'd1,
    REG    = 2'd2
  } state_t;

  logic [1:0] sck_sync, cs_sync, mosi_sync, spec_sync;
  logic       sck_d, cs_d;
  logic       sck_rise, cs_fall, cs_rise;
  logic       mosi_s, spec_s;

  // CS synchroniser resets high so a released reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      spec_sync <= 2'b00;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], bus.spi_sck};
      cs_sync   <= {cs_sync[0], bus.spi_cs_n};
      mosi_sync <= {mosi_sync[0], bus.spi_mosi};
      spec_sync <= {spec_sync[0], bus.special};
      sck_d     <= sck_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_d;
  assign cs_fall  = cs_d & ~cs_sync[1];
  assign cs_rise  = ~cs_d & cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign spec_s   = spec_sync[1];

  state_t              state_reg, state_next;
  logic [N_PERIPH-1:0] sel_reg, sel_next;
  logic [N_PERIPH-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [N_PERIPH-1:0] reg_mux_reg, reg_mux_next;
  logic                frame_err_reg, frame_err_next;
  logic [N_PERIPH-1:0] cs_vec_reg, cs_vec_next;
  logic                busy_reg, busy_next;
  logic                miso_out;

`ifdef SPI_CS_SEQ_READBACK_EN
  logic                sck_fall;
  logic [N_PERIPH-1:0] rb_shreg_reg, rb_shreg_next;
  assign sck_fall = sck_d & ~sck_sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      reg_mux_reg   <= RESET_MUX;
      frame_err_reg <= 1'b0;
      cs_vec_reg    <= '1;
      busy_reg      <= 1'b0;
`ifdef SPI_CS_SEQ_READBACK_EN
      rb_shreg_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      shreg_reg     <= shreg_next;
      bit_cnt_reg   <= bit_cnt_next;
      reg_mux_reg   <= reg_mux_next;
      frame_err_reg <= frame_err_next;
      cs_vec_reg    <= cs_vec_next;
      busy_reg      <= busy_next;
`ifdef SPI_CS_SEQ_READBACK_EN
      rb_shreg_reg  <= rb_shreg_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    shreg_next     = shreg_reg;
    bit_cnt_next   = bit_cnt_reg;
    reg_mux_next   = reg_mux_reg;
    frame_err_next = frame_err_reg;
`ifdef SPI_CS_SEQ_READBACK_EN
    rb_shreg_next  = rb_shreg_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          if (spec_s) begin
            state_next    = REG;
            bit_cnt_next  = '0;
            shreg_next    = '0;
`ifdef SPI_CS_SEQ_READBACK_EN
            rb_shreg_next = reg_mux_reg;
`endif
          end else begin
            state_next = PERIPH;
            sel_next   = reg_mux_reg;
          end
        end
      end
      PERIPH: begin
        if (cs_rise) state_next = IDLE;
      end
      REG: begin
        if (sck_rise) begin
          shreg_next = (shreg_reg << 1) | N_PERIPH'(mosi_s);
          if (bit_cnt_reg != CNT_MAX) bit_cnt_next = bit_cnt_reg + 1'b1;
        end
`ifdef SPI_CS_SEQ_READBACK_EN
        if (sck_fall) rb_shreg_next = rb_shreg_reg << 1;
`endif
        if (cs_rise) begin
          state_next = IDLE;
          if (bit_cnt_reg == CNT_FULL) begin
            reg_mux_next   = shreg_reg;
            frame_err_next = 1'b0;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Outputs follow the next state so CS moves on the same edge as the state change.
    cs_vec_next = (state_next == PERIPH) ? ~sel_next : '1;
    busy_next   = (state_next != IDLE);
  end

  // MISO is a direct pass-through so it adds no clk latency to the peripheral's data.
  always_comb begin
    miso_out = 1'b0;
    if (state_reg == PERIPH) miso_out = |(bus.periph_miso & sel_reg);
`ifdef SPI_CS_SEQ_READBACK_EN
    else if (state_reg == REG) miso_out = rb_shreg_reg[N_PERIPH-1];
`endif
  end

  assign bus.spi_miso  = miso_out;
  assign bus.cs_vec    = cs_vec_reg;
  assign bus.reg_mux   = reg_mux_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Randomised scoreboard bench for spi_cs_sequencer: stimulus pushes frame expectations,
// a monitor pops them on busy edges and checks CS, mux, error flag, latency and MISO.
module tb_spi_cs_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cs_seq_if #(.N_PERIPH(8)) bus ();

  spi_cs_sequencer #(.N_PERIPH(8), .RESET_MUX(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit         is_end;
    bit         is_reg;
    int         nbits;
    logic [7:0] cs;
    logic [7:0] sel;
    logic [7:0] mux;
    logic       err;
    logic [7:0] rb;
  } rec_t;

  rec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_frame = 0;

  logic [7:0] model_mux = 8'h00;
  logic       model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mode-0 frame: sck half period is 4 clk, data changes while sck is low.
  task automatic drive_frame(input bit spec, input int nbits, input logic [31:0] data,
                             input bit wiggle_special);
    @(negedge clk);
    bus.special  = spec;
    bus.spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    if (wiggle_special) bus.special = ~spec;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.spi_mosi    = data[i];
      bus.periph_miso = 8'($urandom);
      if (wiggle_special) bus.special = 1'($urandom);
      repeat (4) @(negedge clk);
      bus.spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    bus.special  = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic reg_frame(input int nbits, input logic [31:0] data);
    rec_t s, e;
    s = '{is_end: 0, is_reg: 1, nbits: nbits, cs: 8'hFF, sel: 8'h00, mux: 8'h00, err: 0, rb: model_mux};
    if (nbits == 8) begin
      model_mux = data[7:0];
      model_err = 1'b0;
    end else begin
      model_err = 1'b1;
    end
    e = '{is_end: 1, is_reg: 1, nbits: nbits, cs: 8'hFF, sel: 8'h00, mux: model_mux, err: model_err, rb: s.rb};
    sb.push_back(s);
    sb.push_back(e);
    n_frame++;
    $display("frame %0d: reg  bits=%0d data=%0h -> mux=%02h err=%0d", n_frame, nbits, data, model_mux, model_err);
    drive_frame(1'b1, nbits, data, 1'b0);
  endtask

  task automatic periph_frame(input int nbits);
    rec_t s, e;
    logic [31:0] d;
    d = $urandom;
    s = '{is_end: 0, is_reg: 0, nbits: nbits, cs: ~model_mux, sel: model_mux, mux: 8'h00, err: 0, rb: 8'h00};
    e = '{is_end: 1, is_reg: 0, nbits: nbits, cs: 8'hFF, sel: model_mux, mux: model_mux, err: model_err, rb: 8'h00};
    sb.push_back(s);
    sb.push_back(e);
    n_frame++;
    $display("frame %0d: data bits=%0d sel=%02h cs=%02h", n_frame, nbits, model_mux, ~model_mux);
    drive_frame(1'b0, nbits, d, 1'b1);
  endtask

  task automatic idle_noise(input int pulses);
    for (int i = 0; i < pulses; i++) begin
      @(negedge clk);
      bus.spi_mosi = 1'($urandom);
      bus.special  = 1'($urandom);
      repeat (3) @(negedge clk);
      bus.spi_sck = 1'b1;
      repeat (3) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    bus.special = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: checks every sample between positive edges.
  logic       mon_busy, mon_cs_n, mon_sck, mon_in;
  int         mon_cyc;
  rec_t       mon_cur, mon_end;
  logic [7:0] mon_cs, mon_mux;
  logic       mon_errf;
  logic [7:0] mon_rb;

  initial begin
    mon_busy = 0; mon_cs_n = 1; mon_sck = 0; mon_in = 0; mon_cyc = 0;
    mon_cs = 8'hFF; mon_mux = 8'h00; mon_errf = 0; mon_rb = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        sb.delete();
        mon_busy = 0; mon_in = 0; mon_cyc = 0;
        mon_cs = 8'hFF; mon_mux = 8'h00; mon_errf = 0;
      end else begin
        mon_cyc = (bus.spi_cs_n != mon_cs_n) ? 1 : ((mon_cyc < 1000) ? mon_cyc + 1 : mon_cyc);
        if (bus.busy && !mon_busy) begin
          chk("sb_has_start", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            mon_cur = sb.pop_front();
            chk("start_order", 32'(mon_cur.is_end), 32'd0);
            chk("cs_assert", 32'(bus.cs_vec), 32'(mon_cur.cs));
            chk("cs_fall_latency", 32'(mon_cyc), 32'd3);
            mon_cs = mon_cur.cs;
            mon_in = 1;
            mon_rb = 8'h00;
          end
        end else if (!bus.busy && mon_busy) begin
          chk("sb_has_end", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            mon_end = sb.pop_front();
            chk("end_order", 32'(mon_end.is_end), 32'd1);
            chk("cs_release", 32'(bus.cs_vec), 32'hFF);
            chk("reg_mux", 32'(bus.reg_mux), 32'(mon_end.mux));
            chk("frame_err", 32'(bus.frame_err), 32'(mon_end.err));
            chk("cs_rise_latency", 32'(mon_cyc), 32'd3);
`ifdef SPI_CS_SEQ_READBACK_EN
            if (mon_end.is_reg && mon_end.nbits == 8)
              chk("readback", 32'(mon_rb), 32'(mon_end.rb));
`endif
            mon_mux  = mon_end.mux;
            mon_errf = mon_end.err;
          end
          mon_cs = 8'hFF;
          mon_in = 0;
        end else begin
          chk("cs_stable", 32'(bus.cs_vec), 32'(mon_cs));
          chk("mux_stable", 32'(bus.reg_mux), 32'(mon_mux));
          chk("err_stable", 32'(bus.frame_err), 32'(mon_errf));
        end
        if (mon_in && bus.spi_sck && !mon_sck) begin
          if (!mon_cur.is_reg) begin
            chk("miso_route", 32'(bus.spi_miso), 32'(|(bus.periph_miso & mon_cur.sel)));
          end else begin
`ifdef SPI_CS_SEQ_READBACK_EN
            mon_rb = {mon_rb[6:0], bus.spi_miso};
`else
            chk("reg_miso_zero", 32'(bus.spi_miso), 32'd0);
`endif
          end
        end
        mon_busy = bus.busy;
      end
      mon_cs_n = bus.spi_cs_n;
      mon_sck  = bus.spi_sck;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d frames expected completion", n_frame);
    $fatal(1, "timeout");
  end

  initial begin
    int r, nb;
    bus.spi_sck = 0; bus.spi_cs_n = 1; bus.spi_mosi = 0; bus.special = 0; bus.periph_miso = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_cs_vec", 32'(bus.cs_vec), 32'hFF);
    chk("rst_reg_mux", 32'(bus.reg_mux), 32'h00);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_miso", 32'(bus.spi_miso), 32'd0);

    reg_frame(8, 32'h02);
    periph_frame(8);
    reg_frame(7, 32'h7F);
    periph_frame(4);
    reg_frame(8, 32'h01);
    idle_noise(3);
    reg_frame(9, 32'h1FF);
    reg_frame(0, 32'h0);
    reg_frame(8, 32'h00);
    periph_frame(8);
    reg_frame(8, 32'hA5);
    reg_frame(8, 32'h3C);
    periph_frame(8);
    reg_frame(8, 32'h96);
    periph_frame(6);

    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) begin
        periph_frame($urandom_range(1, 10));
      end else begin
        r  = $urandom_range(0, 9);
        nb = (r == 0) ? 7 : (r == 1) ? 9 : (r == 2) ? 0 : 8;
        reg_frame(nb, $urandom);
      end
      if ($urandom_range(0, 3) == 0) idle_noise(2);
    end

    // Live data frame interrupted by reset: CS must drop at once.
    reg_frame(8, 32'h01);
    sb.push_back('{is_end: 0, is_reg: 0, nbits: 8, cs: 8'hFE, sel: 8'h01, mux: 8'h00, err: 0, rb: 8'h00});
    $display("frame %0d: data interrupted by reset, sel=01", n_frame + 1);
    @(negedge clk);
    bus.special  = 1'b0;
    bus.spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    bus.special = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_sck = 1'b0;
    repeat (2) @(negedge clk);
    chk("midframe_cs", 32'(bus.cs_vec), 32'hFE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cs", 32'(bus.cs_vec), 32'hFF);
    chk("async_rst_mux", 32'(bus.reg_mux), 32'h00);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    model_mux = 8'h00;
    model_err = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.special  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    periph_frame(8);
    reg_frame(8, 32'h81);
    periph_frame(8);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
